// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-detector pipeline stages.
package edge_pkg;

    localparam int unsigned IN_COLS  = 14;
    localparam int unsigned OUT_COLS = 12;
    localparam int unsigned PIX_W    = 8;
    localparam int unsigned COL_W    = 4;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [IN_COLS-1:0] row_t;
    typedef logic [COL_W-1:0] col_t;

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_45  = 2'd1,
        DIR_90  = 2'd2,
        DIR_135 = 2'd3
    } dir_t;

    typedef dir_t [IN_COLS-1:0] dir_row_t;

    typedef enum logic [1:0] {
        NMS_IDLE,
        NMS_LOAD,
        NMS_PROCESS,
        NMS_DONE
    } nms_state_t;

    localparam col_t LAST_COL = col_t'(OUT_COLS - 1);

endpackage

// File: rtl/nms_cell.sv
// Combinational NMS for one output column: picks the two neighbours along the
// gradient direction and keeps the centre only if it is a local maximum.
// Optional threshold gating with `define NMS_THRESHOLD_EN.
module nms_cell
    import edge_pkg::*;
(
    input  pix_t top_l,
    input  pix_t top_c,
    input  pix_t top_r,
    input  pix_t mid_l,
    input  pix_t mid_c,
    input  pix_t mid_r,
    input  pix_t bot_l,
    input  pix_t bot_c,
    input  pix_t bot_r,
    input  dir_t dir,
`ifdef NMS_THRESHOLD_EN
    input  pix_t thresh,
`endif
    output pix_t pix_out
);

    pix_t n_a;
    pix_t n_b;
    logic keep;

    // Neighbour select by direction, then unsigned local-maximum test (ties kept)
    always_comb begin
        n_a = '0;
        n_b = '0;
        case (dir)
            DIR_0:   begin n_a = mid_l; n_b = mid_r; end
            DIR_45:  begin n_a = top_r; n_b = bot_l; end
            DIR_90:  begin n_a = top_c; n_b = bot_c; end
            DIR_135: begin n_a = top_l; n_b = bot_r; end
            default: begin n_a = '0;    n_b = '0;    end
        endcase
        keep = (mid_c >= n_a) && (mid_c >= n_b);
`ifdef NMS_THRESHOLD_EN
        keep = keep && (mid_c >= thresh);
`endif
        pix_out = keep ? mid_c : '0;
    end

endmodule

// File: rtl/nms_controller.sv
// Non-maximum suppression stage: keeps a 3-row window of gradient magnitude
// and direction, and emits one thinned output column per cycle for the
// middle row. Optional low-threshold gating with `define NMS_THRESHOLD_EN.
module nms_controller
    import edge_pkg::*;
(
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             anchor_moving,
    input  logic [31:0]                      anchor_x,
    input  logic [31:0]                      anchor_y,
    input  logic [IN_COLS-1:0][PIX_W-1:0]    mag_in,
    input  logic [IN_COLS-1:0][1:0]          dir_in,
`ifdef NMS_THRESHOLD_EN
    input  logic [PIX_W-1:0]                 thresh_low,
`endif
    output logic [OUT_COLS-1:0][PIX_W-1:0]   nms_out,
    output logic [31:0]                      anchor_x_out,
    output logic                             nms_final,
    output logic                             busy
);

    nms_state_t state;
    col_t       col;
    row_t       top_mag, mid_mag, bot_mag;
    dir_row_t   top_dir, mid_dir, bot_dir;
    logic [31:0] anchor_x_q;
`ifdef NMS_THRESHOLD_EN
    pix_t       thresh_q;
`endif

    col_t c1, c2;
    pix_t tl, tc, tr, ml, mc, mr, bl, bc, br;
    dir_t dsel;
    pix_t cell_pix;

    // 3x3 window extraction around mid[col+1]
    always_comb begin
        c1   = col + col_t'(1);
        c2   = col + col_t'(2);
        tl   = top_mag[col];
        tc   = top_mag[c1];
        tr   = top_mag[c2];
        ml   = mid_mag[col];
        mc   = mid_mag[c1];
        mr   = mid_mag[c2];
        bl   = bot_mag[col];
        bc   = bot_mag[c1];
        br   = bot_mag[c2];
        dsel = mid_dir[c1];
    end

    nms_cell u_cell (
        .top_l   (tl),
        .top_c   (tc),
        .top_r   (tr),
        .mid_l   (ml),
        .mid_c   (mc),
        .mid_r   (mr),
        .bot_l   (bl),
        .bot_c   (bc),
        .bot_r   (br),
        .dir     (dsel),
`ifdef NMS_THRESHOLD_EN
        .thresh  (thresh_q),
`endif
        .pix_out (cell_pix)
    );

    // Control FSM with row buffers and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= NMS_IDLE;
            col          <= '0;
            top_mag      <= '0;
            mid_mag      <= '0;
            bot_mag      <= '0;
            top_dir      <= dir_row_t'(0);
            mid_dir      <= dir_row_t'(0);
            bot_dir      <= dir_row_t'(0);
            anchor_x_q   <= '0;
`ifdef NMS_THRESHOLD_EN
            thresh_q     <= '0;
`endif
            nms_out      <= '0;
            anchor_x_out <= '0;
            nms_final    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                NMS_IDLE: begin
                    if (anchor_moving) begin
                        // Shift is committed on the accepting edge so the row
                        // need not be held; LOAD then only arms the column scan.
                        if (anchor_y == '0) begin
                            top_mag <= mag_in;
                            mid_mag <= mag_in;
                            bot_mag <= mag_in;
                            top_dir <= dir_row_t'(dir_in);
                            mid_dir <= dir_row_t'(dir_in);
                            bot_dir <= dir_row_t'(dir_in);
                        end else begin
                            top_mag <= mid_mag;
                            mid_mag <= bot_mag;
                            bot_mag <= mag_in;
                            top_dir <= mid_dir;
                            mid_dir <= bot_dir;
                            bot_dir <= dir_row_t'(dir_in);
                        end
                        anchor_x_q <= anchor_x;
                        busy       <= 1'b1;
                        state      <= NMS_LOAD;
                    end
                end
                NMS_LOAD: begin
                    col   <= '0;
`ifdef NMS_THRESHOLD_EN
                    thresh_q <= thresh_low;
`endif
                    state <= NMS_PROCESS;
                end
                NMS_PROCESS: begin
                    nms_out[col] <= cell_pix;
                    if (col == LAST_COL) begin
                        busy         <= 1'b0;
                        nms_final    <= 1'b1;
                        anchor_x_out <= anchor_x_q;
                        state        <= NMS_DONE;
                    end else begin
                        col <= col + col_t'(1);
                    end
                end
                NMS_DONE: begin
                    nms_final <= 1'b0;
                    state     <= NMS_IDLE;
                end
                default: state <= NMS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nms_controller.sv
// Directed, table-driven bench for nms_controller, with hand-written
// sequences for ignored pulses and reset in the middle of a row.
// Threshold checks run when NMS_THRESHOLD_EN is defined.
module tb_nms_controller;

    typedef logic [13:0][7:0] mag_t;
    typedef logic [13:0][1:0] dirr_t;
    typedef logic [11:0][7:0] out_t;

    typedef struct {
        logic [31:0] ay;
        logic [31:0] ax;
        mag_t        mag;
        dirr_t       dir;
        out_t        exp;
    } vec_t;

    logic        tb_clk = 1'b0;
    logic        n_rst;
    logic        anchor_moving;
    logic [31:0] anchor_x;
    logic [31:0] anchor_y;
    mag_t        mag_in;
    dirr_t       dir_in;
    out_t        nms_out;
    logic [31:0] anchor_x_out;
    logic        nms_final;
    logic        busy;
`ifdef NMS_THRESHOLD_EN
    logic [7:0]  thresh_low = 8'd0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 tb_clk = ~tb_clk;

    nms_controller dut (
        .clk           (tb_clk),
        .n_rst         (n_rst),
        .anchor_moving (anchor_moving),
        .anchor_x      (anchor_x),
        .anchor_y      (anchor_y),
        .mag_in        (mag_in),
        .dir_in        (dir_in),
`ifdef NMS_THRESHOLD_EN
        .thresh_low    (thresh_low),
`endif
        .nms_out       (nms_out),
        .anchor_x_out  (anchor_x_out),
        .nms_final     (nms_final),
        .busy          (busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic mag_t flat_mag(input logic [7:0] v);
        mag_t r;
        for (int i = 0; i < 14; i++) r[i] = v;
        return r;
    endfunction

    function automatic dirr_t flat_dir(input logic [1:0] d);
        dirr_t r;
        for (int i = 0; i < 14; i++) r[i] = d;
        return r;
    endfunction

    function automatic out_t flat_out(input logic [7:0] v);
        out_t r;
        for (int i = 0; i < 12; i++) r[i] = v;
        return r;
    endfunction

    task automatic add(input logic [31:0] ay, input logic [31:0] ax, input mag_t m,
                       input dirr_t d, input out_t e);
        vec_t v;
        v.ay = ay; v.ax = ax; v.mag = m; v.dir = d; v.exp = e;
        vecs.push_back(v);
    endtask

    // Called at a negedge; returns at the next negedge (pulse cycle k=1)
    task automatic pulse(input logic [31:0] ay, input logic [31:0] ax, input mag_t m, input dirr_t d);
        anchor_y = ay; anchor_x = ax; mag_in = m; dir_in = d; anchor_moving = 1'b1;
        @(negedge tb_clk);
        anchor_moving = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        lat = 0;
        pulse(v.ay, v.ax, v.mag, v.dir);
        chk({tag, "_busy_load"}, busy, 1);
        for (int k = 2; k <= 30; k++) begin
            @(negedge tb_clk);
            if (nms_final) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, lat, 14);
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_anchor_x_out"}, anchor_x_out, v.ax);
        for (int c = 0; c < 12; c++)
            chk($sformatf("%s_col%0d", tag, c), nms_out[c], v.exp[c]);
        @(negedge tb_clk);
        chk({tag, "_final_width"}, nms_final, 0);
    endtask

    initial begin
        mag_t  m;
        out_t  e;
        mag_t  p_row, r_row;
        out_t  p_out;
        vec_t  v;
        int    finals, lat;

        // Table of directed rows
        add(0, 100, flat_mag(50), flat_dir(0), flat_out(50));
        m = flat_mag(10); m[5] = 200;
        e = flat_out(10); e[4] = 200; e[3] = 0; e[5] = 0;
        add(0, 101, m, flat_dir(0), e);
        add(0, 102, flat_mag(150), flat_dir(2), flat_out(150));
        add(1, 103, flat_mag(100), flat_dir(2), flat_out(150));
        add(2, 104, flat_mag(50),  flat_dir(0), flat_out(0));
        add(0, 105, flat_mag(90),  flat_dir(2), flat_out(90));
        add(1, 106, flat_mag(100), flat_dir(2), flat_out(0));
        add(2, 107, flat_mag(90),  flat_dir(2), flat_out(100));
        p_row = flat_mag(50); p_row[7] = 150;
        r_row = flat_mag(50); r_row[2] = 150;
        p_out = flat_out(50); p_out[6] = 150; p_out[5] = 0; p_out[7] = 0;
        add(0, 108, p_row, flat_dir(0), p_out);
        add(1, 109, flat_mag(100), flat_dir(1), p_out);
        e = flat_out(100); e[2] = 0; e[5] = 0;
        add(2, 110, r_row, flat_dir(0), e);
        add(0, 111, p_row, flat_dir(0), p_out);
        add(1, 112, flat_mag(100), flat_dir(3), p_out);
        e = flat_out(100); e[0] = 0; e[7] = 0;
        add(2, 113, r_row, flat_dir(0), e);
        m = flat_mag(0); m[3] = 255;
        e = flat_out(0); e[2] = 255;
        add(0, 114, m, flat_dir(0), e);

        // Reset state
        n_rst = 1'b0; anchor_moving = 1'b0; anchor_x = '0; anchor_y = '0;
        mag_in = '0; dir_in = '0;
        repeat (3) @(negedge tb_clk);
        chk("rst_nms_out", nms_out, 0);
        chk("rst_anchor_x_out", anchor_x_out, 0);
        chk("rst_nms_final", nms_final, 0);
        chk("rst_busy", busy, 0);
        n_rst = 1'b1;
        @(negedge tb_clk);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Pulses during PROCESS and during DONE are dropped
        finals = 0; lat = 0;
        pulse(0, 200, flat_mag(50), flat_dir(0));
        for (int k = 2; k <= 34; k++) begin
            @(negedge tb_clk);
            if (nms_final) begin
                finals++;
                if (lat == 0) lat = k;
            end
            if (k == 7 || k == 14) begin
                anchor_y = 0; anchor_x = (k == 7) ? 999 : 888;
                mag_in = flat_mag(200); dir_in = flat_dir(0); anchor_moving = 1'b1;
            end else begin
                anchor_moving = 1'b0;
            end
        end
        chk("ign_final_count", finals, 1);
        chk("ign_latency", lat, 14);
        chk("ign_nms_out", nms_out, flat_out(50));
        chk("ign_anchor_x_out", anchor_x_out, 200);
        chk("ign_busy", busy, 0);
        v.ay = 1; v.ax = 201; v.mag = flat_mag(50); v.dir = flat_dir(0); v.exp = flat_out(50);
        run_vec(v, "ign_buffers");

        // Reset during PROCESS cycle 6
        finals = 0;
        pulse(0, 300, flat_mag(77), flat_dir(0));
        for (int k = 2; k <= 30; k++) begin
            @(negedge tb_clk);
            if (nms_final) finals++;
            if (k == 8) n_rst = 1'b0;
            if (k == 9) begin
                chk("mid_rst_nms_out", nms_out, 0);
                chk("mid_rst_busy", busy, 0);
                chk("mid_rst_anchor_x_out", anchor_x_out, 0);
            end
            if (k == 10) n_rst = 1'b1;
        end
        chk("mid_rst_no_final", finals, 0);
        v.ay = 0; v.ax = 301; v.mag = flat_mag(50); v.dir = flat_dir(0); v.exp = flat_out(50);
        run_vec(v, "after_rst");

`ifdef NMS_THRESHOLD_EN
        thresh_low = 8'd60;
        v.ay = 0; v.ax = 400; v.mag = flat_mag(50); v.dir = flat_dir(0); v.exp = flat_out(0);
        run_vec(v, "thr60");
        thresh_low = 8'd40;
        v.ax = 401; v.exp = flat_out(50);
        run_vec(v, "thr40");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
